// File: rtl/nonce_scanner_if.sv
// Scanner control, finisher and golden-nonce queue signals.
// The master side (controller/testbench) drives requests, hashes and queue ready;
// the slave side (nonce_scanner) drives the nonce, status and queue head.
interface nonce_scanner_if;
   logic         start;
   logic         abort;
   logic [31:0]  nonce_start;
   logic [31:0]  nonce_end;
   logic         slot_tick;
   logic [255:0] hash;
   logic [31:0]  out_nonce;
   logic         busy;
   logic         done;
   logic         found_valid;
   logic [31:0]  found_nonce;
   logic         found_ready;
   logic         overflow;

   modport master (
      output start, abort, nonce_start, nonce_end, slot_tick, hash, found_ready,
      input  out_nonce, busy, done, found_valid, found_nonce, overflow
   );

   modport slave (
      input  start, abort, nonce_start, nonce_end, slot_tick, hash, found_ready,
      output out_nonce, busy, done, found_valid, found_nonce, overflow
   );
endinterface

// File: rtl/nonce_scanner.sv
// Nonce scanner: steps the finisher's in_nonce once per hash slot, pairs each
// returning hash with the nonce that produced it (LATENCY slots earlier) and
// queues nonces whose hash has ZERO_BITS leading zeros in a 2-entry FIFO.
module nonce_scanner #(
   parameter int LATENCY   = 2,
   parameter int ZERO_BITS = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   nonce_scanner_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                      state, state_nx;
   logic [31:0]                 cur_nonce;
   logic [31:0]                 end_nonce;
   logic [LATENCY-1:0]          hist_vld;
   logic [LATENCY-1:0][31:0]    hist_nonce;
   logic [2:0]                  drain_cnt;
   logic                        done_q;
   logic                        overflow_q;
   logic [1:0][31:0]            q_mem, q_mem_nx;
   logic [1:0]                  q_cnt, q_cnt_nx;

   logic tick, match, push, pop, drop, last_drain, go;
   logic unused_hash;

   // A tick only counts while scanning; abort overrides it.
   assign tick       = bus.slot_tick & (state != S_IDLE) & ~bus.abort;
   assign go         = (state == S_IDLE) & bus.start & ~bus.abort;
   assign match      = (bus.hash[255 -: ZERO_BITS] == '0);
   assign push       = tick & hist_vld[LATENCY-1] & match;
   assign pop        = bus.found_valid & bus.found_ready;
   assign last_drain = (state == S_DRAIN) & tick & (drain_cnt == 3'(LATENCY-1));
   assign unused_hash = ^bus.hash[255-ZERO_BITS:0];

   assign bus.out_nonce   = cur_nonce;
   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = done_q;
   assign bus.found_valid = (q_cnt != 2'd0);
   assign bus.found_nonce = q_mem[0];
   assign bus.overflow    = overflow_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state: RUN until the last nonce is issued, then DRAIN LATENCY ticks.
   always_comb begin
      state_nx = state;
      if (bus.abort) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (bus.start) state_nx = S_RUN;
            S_RUN:   if (bus.slot_tick && cur_nonce == end_nonce) state_nx = S_DRAIN;
            S_DRAIN: if (last_drain) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Nonce counter, in-flight history shift register and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_nonce  <= '0;
         end_nonce  <= '0;
         hist_vld   <= '0;
         hist_nonce <= '0;
         drain_cnt  <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= last_drain;
         if (bus.abort) begin
            hist_vld  <= '0;
            drain_cnt <= '0;
         end else if (go) begin
            cur_nonce <= bus.nonce_start;
            end_nonce <= bus.nonce_end;
            hist_vld  <= '0;
            drain_cnt <= '0;
         end else if (tick) begin
            for (int i = LATENCY-1; i > 0; i--) begin
               hist_vld[i]   <= hist_vld[i-1];
               hist_nonce[i] <= hist_nonce[i-1];
            end
            // Only RUN slots carry a real nonce; DRAIN slots are bubbles.
            hist_vld[0]   <= (state == S_RUN);
            hist_nonce[0] <= cur_nonce;
            if (state == S_RUN && cur_nonce != end_nonce) cur_nonce <= cur_nonce + 32'd1;
            if (state == S_DRAIN) drain_cnt <= drain_cnt + 3'd1;
         end
      end
   end

   // Queue next-state; a push into a full queue survives only if the head pops.
   always_comb begin
      q_mem_nx = q_mem;
      q_cnt_nx = q_cnt;
      drop     = 1'b0;
      case ({push, pop})
         2'b01: begin
            q_mem_nx[0] = q_mem[1];
            q_cnt_nx    = q_cnt - 2'd1;
         end
         2'b10: begin
            if (q_cnt == 2'd0) begin
               q_mem_nx[0] = hist_nonce[LATENCY-1];
               q_cnt_nx    = 2'd1;
            end else if (q_cnt == 2'd1) begin
               q_mem_nx[1] = hist_nonce[LATENCY-1];
               q_cnt_nx    = 2'd2;
            end else begin
               drop = 1'b1;
            end
         end
         2'b11: begin
            if (q_cnt == 2'd1) begin
               q_mem_nx[0] = hist_nonce[LATENCY-1];
            end else begin
               q_mem_nx[0] = q_mem[1];
               q_mem_nx[1] = hist_nonce[LATENCY-1];
            end
         end
         default: ;
      endcase
   end

   // Queue storage and sticky overflow (cleared when a new scan starts).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_mem      <= '0;
         q_cnt      <= '0;
         overflow_q <= 1'b0;
      end else begin
         q_mem <= q_mem_nx;
         q_cnt <= q_cnt_nx;
         if (go)        overflow_q <= 1'b0;
         else if (drop) overflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nonce_scanner.sv
// Scoreboard bench for nonce_scanner: the driver derives expected golden nonces
// from the scan rules and queues them; a monitor compares every queue pop.
module tb_nonce_scanner;
   localparam int LAT = 2;
   localparam int ZB  = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nonce_scanner_if bus();

   nonce_scanner #(.LATENCY(LAT), .ZERO_BITS(ZB)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   bit          exp_ovf = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mk_hash(input bit m);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      if (m) begin
         r[255 -: ZB] = '0;
         if ($urandom_range(1) == 0) r[255-ZB] = 1'b1;
      end else if ($urandom_range(3) == 0) begin
         r[255 -: ZB] = '0;
         r[256-ZB] = 1'b1;
      end else begin
         r[256 - ZB + int'($urandom_range(ZB-1))] = 1'b1;
      end
      return r;
   endfunction

   // Monitor: every accepted queue head must match the oldest expected nonce.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.done) done_cnt++;
         if (bus.found_valid && bus.found_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: got %0h expected no entry", bus.found_nonce);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("found_nonce", bus.found_nonce, mon_exp);
            end
         end
      end
   end

   // One scan; tick t (1-based) checks the nonce issued at tick t-LAT.
   task automatic run_scan(input logic [31:0] ns, input logic [31:0] ne, input bit rnd,
                           input logic [31:0] mask, input int rdy_tick);
      int n, tt, d0;
      bit m;
      logic [31:0] cur;
      n  = int'(ne - ns) + 1;
      tt = n + LAT;
      d0 = done_cnt;
      exp_ovf = 1'b0;
      bus.start = 1'b1; bus.nonce_start = ns; bus.nonce_end = ne;
      step();
      bus.start = 1'b0;
      chk("start_nonce", bus.out_nonce, ns);
      chk("busy_start", bus.busy, 1);
      for (int t = 1; t <= tt; t++) begin
         repeat (5) step();
         cur = (t <= n) ? ns + 32'(t-1) : ne;
         chk("out_nonce", bus.out_nonce, cur);
         m = rnd ? ($urandom_range(2) == 0) : mask[t];
         if (t == rdy_tick) bus.found_ready = 1'b1;
         if (m && t > LAT && t - LAT <= n) begin
            if (exp_q.size() >= 2 && !bus.found_ready) exp_ovf = 1'b1;
            else exp_q.push_back(ns + 32'(t - LAT - 1));
         end
         bus.hash = mk_hash(m);
         bus.slot_tick = 1'b1;
         step();
         bus.slot_tick = 1'b0;
         if (t < tt) chk("done_early", bus.done, 0);
      end
      chk("done", bus.done, 1);
      chk("busy_end", bus.busy, 0);
      step();
      chk("done_count", done_cnt - d0, 1);
      chk("overflow", bus.overflow, exp_ovf);
   endtask

   task automatic drain_wait();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic plain_tick(input bit m, input bit ab);
      repeat (5) step();
      bus.hash = mk_hash(m);
      bus.slot_tick = 1'b1;
      bus.abort = ab;
      step();
      bus.slot_tick = 1'b0;
      bus.abort = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ns;
      bus.start = 0; bus.abort = 0; bus.nonce_start = 0; bus.nonce_end = 0;
      bus.slot_tick = 0; bus.hash = '0; bus.found_ready = 1'b1;
      repeat (3) step();
      chk("rst_out_nonce", bus.out_nonce, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_found_valid", bus.found_valid, 0);
      chk("rst_overflow", bus.overflow, 0);
      rst_n = 1'b1;
      step();

      // Reset in the middle of a scan.
      bus.start = 1'b1; bus.nonce_start = 32'h40; bus.nonce_end = 32'h60;
      step();
      bus.start = 1'b0;
      for (int t = 0; t < 5; t++) plain_tick(1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_nonce", bus.out_nonce, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_found_valid", bus.found_valid, 0);
      chk("midrst_found_nonce", bus.found_nonce, 0);
      chk("midrst_overflow", bus.overflow, 0);
      repeat (3) step();
      rst_n = 1'b1;
      exp_q.delete();
      step();

      // Basic scan, no matches.
      run_scan(32'h10, 32'h13, 1'b0, 32'h0, 0);
      chk("no_found", bus.found_valid, 0);

      // Single match held until consumer accepts.
      bus.found_ready = 1'b0;
      run_scan(32'h10, 32'h13, 1'b0, 32'h8, 0);
      repeat (3) step();
      chk("hold_valid", bus.found_valid, 1);
      chk("hold_nonce", bus.found_nonce, exp_q.size() ? exp_q[0] : 32'hDEAD_BEEF);
      bus.found_ready = 1'b1;
      drain_wait();

      // Wrap through zero.
      run_scan(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32'h3C, 0);
      drain_wait();

      // Three consecutive matches into a stalled queue: third dropped.
      bus.found_ready = 1'b0;
      run_scan(32'h100, 32'h104, 1'b0, 32'h38, 0);
      chk("ovf_head", bus.found_nonce, exp_q.size() ? exp_q[0] : 32'hDEAD_BEEF);
      bus.found_ready = 1'b1;
      drain_wait();

      // Same, but consumer pops on the third push: nothing dropped.
      bus.found_ready = 1'b0;
      run_scan(32'h100, 32'h104, 1'b0, 32'h38, 5);
      drain_wait();

      // Abort together with a matching tick in DRAIN, then restart next cycle.
      bus.start = 1'b1; bus.nonce_start = 32'h20; bus.nonce_end = 32'h21;
      step();
      bus.start = 1'b0;
      plain_tick(1'b0, 1'b0);
      plain_tick(1'b0, 1'b0);
      plain_tick(1'b1, 1'b1);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_out_nonce", bus.out_nonce, 32'h21);
      run_scan(32'h30, 32'h32, 1'b1, 32'h0, 0);
      drain_wait();

      // Random scans.
      for (int k = 0; k < 8; k++) begin
         ns = (k == 0) ? 32'hFFFF_FFFD : $urandom;
         run_scan(ns, ns + 32'($urandom_range(6)), 1'b1, 32'h0, 0);
         drain_wait();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
